// File: rtl/microwave_pkg.sv
// Shared types for the cook sequencer: FSM state encoding, BCD cook time, power helpers.
// Pure declarations, no logic; no latency or backpressure applies.
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_COOK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [3:0] POWER_FULL = 4'd10;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] tens;
        logic [3:0] secs;
    } bcd_time_t;

    // Keypad entry scrolls digits in from the right; the old minutes digit falls off.
    function automatic bcd_time_t shift_in(input bcd_time_t t, input logic [3:0] d);
        bcd_time_t r;
        r.min  = t.tens;
        r.tens = t.secs;
        r.secs = d;
        return r;
    endfunction

    function automatic logic [3:0] power_from_digit(input logic [3:0] d);
        return (d == 4'd0) ? POWER_FULL : d;
    endfunction

endpackage

// File: rtl/cook_sequencer_if.sv
// Keypad, timer and magnetron signals between the sequencer and its neighbours.
// Level/strobe signals only; no handshake, so there is no backpressure.
interface cook_sequencer_if;
    logic        pgt_1Hz;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        power_key;
    logic        stage_key;
    logic        startn;
    logic        stopn;
    logic        clearn;
    logic        door_closed;
    logic        timer_done;
    logic [11:0] timer_value;
    logic        timer_loadn;
    logic        timer_enable;
    logic        mag_on;
    logic        stage;
    logic        done;
    logic        busy;

    modport slave (
        input  pgt_1Hz, key_valid, key_digit, power_key, stage_key,
               startn, stopn, clearn, door_closed, timer_done,
        output timer_value, timer_loadn, timer_enable, mag_on, stage, done, busy
    );

    modport master (
        output pgt_1Hz, key_valid, key_digit, power_key, stage_key,
               startn, stopn, clearn, door_closed, timer_done,
        input  timer_value, timer_loadn, timer_enable, mag_on, stage, done, busy
    );
endinterface

// File: rtl/cook_sequencer_duty_cycler.sv
// Power duty window: counts 1 Hz ticks modulo POWER_WINDOW, on-phase while window < power.
// on_phase_o is combinational from the window register; no backpressure.
module duty_cycler #(
    parameter int POWER_WINDOW = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr_i,
    input  logic       adv_i,
    input  logic [3:0] power_i,
    output logic       on_phase_o
);
    localparam logic [3:0] WIN_LAST = 4'(POWER_WINDOW - 1);

    logic [3:0] win_q, win_d;

    always_comb begin
        win_d = win_q;
        if (clr_i) begin
            win_d = 4'd0;
        end else if (adv_i) begin
            win_d = (win_q == WIN_LAST) ? 4'd0 : win_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_q <= 4'd0;
        end else begin
            win_q <= win_d;
        end
    end

    assign on_phase_o = (win_q < power_i);

endmodule

// File: rtl/cook_sequencer.sv
// Two-stage cook program sequencer: keypad capture, timer load/enable, magnetron duty, safety.
// Timer load strobe one cycle after start; door open kills mag_on combinationally; no backpressure.
module cook_sequencer
    import microwave_pkg::*;
#(
    parameter int DONE_TICKS   = 3,
    parameter int POWER_WINDOW = 10
) (
    input  logic             clk,
    input  logic             resetn,
    cook_sequencer_if.slave  bus
);
    localparam logic [7:0] DONE_LAST = 8'(DONE_TICKS - 1);

    state_t     state_q, state_d;
    bcd_time_t  time1_q, time1_d;
    bcd_time_t  time2_q, time2_d;
    logic [3:0] pow1_q, pow1_d;
    logic [3:0] pow2_q, pow2_d;
    logic       stage_q, stage_d;
    logic       pend_q, pend_d;
    logic [7:0] dcnt_q, dcnt_d;

    logic       digit_ok;
    logic       start_ok;
    logic       prog_clr;
    logic       win_clr;
    logic       on_phase;
    bcd_time_t  time_sel;
    logic [3:0] pow_sel;

    assign digit_ok = bus.key_valid && (bus.key_digit <= 4'd9);
    assign start_ok = !bus.startn && bus.door_closed && (time1_q != '0) &&
                      (time1_q.tens <= 4'd5) && (time2_q.tens <= 4'd5);
    assign time_sel = stage_q ? time2_q : time1_q;
    assign pow_sel  = stage_q ? pow2_q  : pow1_q;

    always_comb begin
        state_d  = state_q;
        time1_d  = time1_q;
        time2_d  = time2_q;
        pow1_d   = pow1_q;
        pow2_d   = pow2_q;
        stage_d  = stage_q;
        pend_d   = pend_q;
        dcnt_d   = dcnt_q;
        prog_clr = 1'b0;
        win_clr  = 1'b0;

        if (!bus.clearn) begin
            state_d  = ST_IDLE;
            prog_clr = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_ENTRY: begin
                    if (state_q == ST_ENTRY && start_ok) begin
                        state_d = ST_LOAD;
                        stage_d = 1'b0;
                        pend_d  = 1'b0;
                    end else begin
                        if (bus.power_key) begin
                            pend_d = 1'b1;
                        end
                        if (state_q == ST_ENTRY && bus.stage_key) begin
                            stage_d = 1'b1;
                        end
                        if (digit_ok) begin
                            state_d = ST_ENTRY;
                            if (pend_q) begin
                                pend_d = 1'b0;
                                if (stage_q) pow2_d = power_from_digit(bus.key_digit);
                                else         pow1_d = power_from_digit(bus.key_digit);
                            end else if (stage_q) begin
                                time2_d = shift_in(time2_q, bus.key_digit);
                            end else begin
                                time1_d = shift_in(time1_q, bus.key_digit);
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    win_clr = 1'b1;
                    state_d = ST_COOK;
                end
                ST_COOK: begin
                    // Safety beats completion: a done seen with the door opening is replayed on resume.
                    if (!bus.stopn || !bus.door_closed) begin
                        state_d = ST_PAUSE;
                    end else if (bus.timer_done) begin
                        if (!stage_q && (time2_q != '0)) begin
                            stage_d = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                            dcnt_d  = 8'd0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.stopn && !bus.startn && bus.door_closed) begin
                        state_d = ST_COOK;
                    end
                end
                ST_DONE: begin
                    if (bus.pgt_1Hz) begin
                        if (dcnt_q == DONE_LAST) begin
                            state_d  = ST_IDLE;
                            prog_clr = 1'b1;
                        end else begin
                            dcnt_d = dcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    prog_clr = 1'b1;
                end
            endcase
        end

        if (prog_clr) begin
            time1_d = '0;
            time2_d = '0;
            pow1_d  = POWER_FULL;
            pow2_d  = POWER_FULL;
            stage_d = 1'b0;
            pend_d  = 1'b0;
            dcnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            time1_q <= '0;
            time2_q <= '0;
            pow1_q  <= POWER_FULL;
            pow2_q  <= POWER_FULL;
            stage_q <= 1'b0;
            pend_q  <= 1'b0;
            dcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            time1_q <= time1_d;
            time2_q <= time2_d;
            pow1_q  <= pow1_d;
            pow2_q  <= pow2_d;
            stage_q <= stage_d;
            pend_q  <= pend_d;
            dcnt_q  <= dcnt_d;
        end
    end

    duty_cycler #(
        .POWER_WINDOW (POWER_WINDOW)
    ) u_duty (
        .clk        (clk),
        .resetn     (resetn),
        .clr_i      (win_clr),
        .adv_i      ((state_q == ST_COOK) && bus.pgt_1Hz),
        .power_i    (pow_sel),
        .on_phase_o (on_phase)
    );

    assign bus.timer_value  = (state_q == ST_LOAD) ? time_sel : 12'h000;
    assign bus.timer_loadn  = (state_q != ST_LOAD);
    assign bus.timer_enable = (state_q == ST_COOK);
    assign bus.mag_on       = (state_q == ST_COOK) && bus.door_closed && on_phase;
    assign bus.stage        = stage_q;
    assign bus.done         = (state_q == ST_DONE);
    assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_COOK) || (state_q == ST_PAUSE);

endmodule
